// File: rtl/comparator_bist.sv
// On-chip exhaustive tester for a WIDTH-input, 1-output combinational unit:
// walks every input code, captures the response and compares it to a golden table.
module comparator_bist #(
    parameter int                  WIDTH    = 4,
    parameter int                  SETTLE   = 1,
    parameter logic [2**WIDTH-1:0] EXPECTED = 16'hFC00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dut_out,
    output logic [WIDTH-1:0]      dut_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2**WIDTH-1:0]   result,
    output logic [WIDTH:0]        fail_count,
    output logic [WIDTH-1:0]      fail_index
);

    localparam int NCODES = 2**WIDTH;
    localparam int HW     = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    localparam logic [HW-1:0]    SETTLE_CNT = HW'(SETTLE);
    localparam logic [WIDTH-1:0] LAST_CODE  = {WIDTH{1'b1}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [WIDTH-1:0]  dut_in_q, dut_in_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [NCODES-1:0] result_q, result_d;
    logic [WIDTH:0]    fail_count_q, fail_count_d;
    logic [WIDTH-1:0]  fail_index_q, fail_index_d;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        dut_in_d     = dut_in_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        result_d     = result_q;
        fail_count_d = fail_count_q;
        fail_index_d = fail_index_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RUN;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    dut_in_d     = '0;
                    hold_d       = '0;
                    result_d     = '0;
                    fail_count_d = '0;
                    fail_index_d = '0;
                end
            end
            S_RUN: begin
                if (hold_q == SETTLE_CNT) begin
                    result_d[dut_in_q] = dut_out;
                    if (dut_out != EXPECTED[dut_in_q]) begin
                        fail_count_d = fail_count_q + (WIDTH+1)'(1);
                        if (fail_count_q == '0) begin
                            fail_index_d = dut_in_q;
                        end
                    end
                    hold_d = '0;
                    // Final capture and DONE entry share an edge so status is complete when done rises.
                    if (dut_in_q == LAST_CODE) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (fail_count_d == '0);
                    end else begin
                        dut_in_d = dut_in_q + WIDTH'(1);
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            dut_in_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            result_q     <= '0;
            fail_count_q <= '0;
            fail_index_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            dut_in_q     <= dut_in_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            result_q     <= result_d;
            fail_count_q <= fail_count_d;
            fail_index_q <= fail_index_d;
        end
    end

    assign dut_in     = dut_in_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign result     = result_q;
    assign fail_count = fail_count_q;
    assign fail_index = fail_index_q;

endmodule
